// File: rtl/rfft_out_reader.sv
// rfft_out_reader: collects the four-lane scattered writes of the rfft_4pt core
// into a local buffer and, once a frame is complete, streams the words out one
// per valid/ready transfer in natural or bit-reversed index order.
module rfft_out_reader #(
    parameter int ADDR_BIT   = 3,
    parameter int DATA_BIT   = 16,
    parameter int MEM_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_BIT*4-1:0] wr_addr,
    input  logic [DATA_BIT-1:0]   wr_data0,
    input  logic [DATA_BIT-1:0]   wr_data1,
    input  logic [DATA_BIT-1:0]   wr_data2,
    input  logic [DATA_BIT-1:0]   wr_data3,
    input  logic                  wr_last,
    output logic                  wr_ready,
    input  logic                  bitrev_en,
    output logic [DATA_BIT-1:0]   out_data,
    output logic [ADDR_BIT-1:0]   out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    input  logic                  err_clr,
    output logic                  err_dup,
    output logic                  err_overrun
);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;
    localparam logic [ADDR_BIT-1:0] LAST_PTR = ADDR_BIT'(MEM_HEIGHT - 1);

    logic [0:0]          state_q, state_d;
    logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic                bitrev_q, bitrev_d;
    logic                err_dup_q, err_dup_d;
    logic                err_overrun_q, err_overrun_d;

    logic [DATA_BIT-1:0] mem_q [MEM_HEIGHT];

    logic [ADDR_BIT-1:0] lane_addr_s [4];
    logic [DATA_BIT-1:0] lane_data_s [4];
    logic                dup_s;
    logic                mem_we_s;
    logic                xfer_s;

    // Mirror the pointer bits so index b of the input lands at ADDR_BIT-1-b.
    function automatic logic [ADDR_BIT-1:0] bit_reverse(input logic [ADDR_BIT-1:0] v);
        logic [ADDR_BIT-1:0] r;
        r = '0;
        for (int b = 0; b < ADDR_BIT; b++) begin
            r[b] = v[ADDR_BIT-1-b];
        end
        return r;
    endfunction

    // Unpack the lane addresses and data into indexable arrays.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr_s[k] = wr_addr[k*ADDR_BIT +: ADDR_BIT];
        end
        lane_data_s[0] = wr_data0;
        lane_data_s[1] = wr_data1;
        lane_data_s[2] = wr_data2;
        lane_data_s[3] = wr_data3;
    end

    // Flag any pair of lanes in one write that target the same entry.
    always_comb begin
        dup_s = 1'b0;
        for (int a = 0; a < 4; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                if (lane_addr_s[a] == lane_addr_s[b]) begin
                    dup_s = 1'b1;
                end else begin
                    dup_s = dup_s;
                end
            end
        end
    end

    // Output decode from the registered state and read pointer.
    always_comb begin
        wr_ready    = (state_q == ST_FILL);
        out_valid   = (state_q == ST_DRAIN);
        out_last    = (state_q == ST_DRAIN) && (rd_ptr_q == LAST_PTR);
        out_index   = bitrev_q ? bit_reverse(rd_ptr_q) : rd_ptr_q;
        out_data    = mem_q[out_index];
        err_dup     = err_dup_q;
        err_overrun = err_overrun_q;
        mem_we_s    = (state_q == ST_FILL) && wr_en;
        xfer_s      = out_valid && out_ready;
    end

    // Next-state logic: frame fill / drain sequencing and sticky error flags.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        bitrev_d      = bitrev_q;
        err_dup_d     = err_clr ? 1'b0 : err_dup_q;
        err_overrun_d = err_clr ? 1'b0 : err_overrun_q;
        case (state_q)
            ST_FILL: begin
                if (wr_en) begin
                    if (dup_s) begin
                        err_dup_d = 1'b1;
                    end else begin
                        err_dup_d = err_dup_d;
                    end
                    if (wr_last) begin
                        state_d  = ST_DRAIN;
                        rd_ptr_d = '0;
                        bitrev_d = bitrev_en;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (wr_en) begin
                    err_overrun_d = 1'b1;
                end else begin
                    err_overrun_d = err_overrun_d;
                end
                if (xfer_s) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        state_d  = ST_FILL;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_BIT'(1);
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
            end
            default: begin
                state_d  = ST_FILL;
                rd_ptr_d = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            rd_ptr_q      <= '0;
            bitrev_q      <= 1'b0;
            err_dup_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            bitrev_q      <= bitrev_d;
            err_dup_q     <= err_dup_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Buffer write; lanes are applied in ascending order so the highest lane wins.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[lane_addr_s[k]] <= lane_data_s[k];
            end
        end
    end

endmodule
